// File: rtl/ibus_uncached_responder_pkg.sv
// Shared CPU types and AXI constants used by the uncached instruction-fetch responder.
package ibus_uncached_responder_pkg;

  typedef logic [31:0] phys_t;
  typedef logic [31:0] uint32_t;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } ibus_resp_state_t;

  function automatic phys_t word_align(input phys_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ibus_uncached_responder_if.sv
// Fetch-side request/response handshake plus the AXI AR/R channels it is served through.
interface ibus_uncached_responder_if #(
  parameter int ID_WIDTH = 4
);
  import ibus_uncached_responder_pkg::*;

  logic                ibus_read;
  phys_t               ibus_addr;
  logic                ibus_flush;
  logic                ibus_stall;
  logic                ibus_ready;
  logic                ibus_valid;
  uint32_t             ibus_rddata;

  logic [ID_WIDTH-1:0] mem_arid;
  phys_t               mem_araddr;
  logic [7:0]          mem_arlen;
  logic [2:0]          mem_arsize;
  logic                mem_arvalid;
  logic                mem_arready;
  logic                mem_rvalid;
  uint32_t             mem_rdata;
  logic                mem_rready;

  // slave: the responder; master: fetch stage and AXI fabric around it
  modport slave (
    input  ibus_read, ibus_addr, ibus_flush, ibus_stall,
    output ibus_ready, ibus_valid, ibus_rddata,
    output mem_arid, mem_araddr, mem_arlen, mem_arsize, mem_arvalid, mem_rready,
    input  mem_arready, mem_rvalid, mem_rdata
  );

  modport master (
    output ibus_read, ibus_addr, ibus_flush, ibus_stall,
    input  ibus_ready, ibus_valid, ibus_rddata,
    input  mem_arid, mem_araddr, mem_arlen, mem_arsize, mem_arvalid, mem_rready,
    output mem_arready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/ibus_uncached_responder.sv
// Serves one instruction fetch at a time through a single-beat AXI read, with flush and stall.
//
// state | meaning
// IDLE  | no request outstanding, ready for a fetch
// ADDR  | AR presented, waiting for mem_arready
// DATA  | waiting for the R beat (discarded if drop is set)
// DONE  | response held on ibus_rddata until consumed or flushed
module ibus_uncached_responder
  import ibus_uncached_responder_pkg::*;
#(
  parameter int                  ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0] AR_ID    = '0
) (
  input logic                      clk,
  input logic                      rst,
  ibus_uncached_responder_if.slave bus
);

  ibus_resp_state_t state_q, state_nxt;
  logic             drop_q, drop_nxt;
  phys_t            addr_q, addr_nxt;
  uint32_t          rddata_q, rddata_nxt;
  logic             ready;
  logic             accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      drop_q   <= 1'b0;
      addr_q   <= '0;
      rddata_q <= '0;
    end else begin
      state_q  <= state_nxt;
      drop_q   <= drop_nxt;
      addr_q   <= addr_nxt;
      rddata_q <= rddata_nxt;
    end
  end

  // A flush in DONE retires the held word, so the slot is free for a same-cycle request.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      DONE:    ready = bus.ibus_flush | ~bus.ibus_stall;
      default: ready = 1'b0;
    endcase
  end

  assign accept = ready & bus.ibus_read;

  always_comb begin
    state_nxt  = state_q;
    drop_nxt   = drop_q;
    addr_nxt   = addr_q;
    rddata_nxt = rddata_q;
    case (state_q)
      IDLE: begin
        if (accept) state_nxt = ADDR;
      end
      ADDR: begin
        if (bus.ibus_flush) drop_nxt = 1'b1;
        if (bus.mem_arready) state_nxt = DATA;
      end
      DATA: begin
        if (bus.ibus_flush) drop_nxt = 1'b1;
        if (bus.mem_rvalid) begin
          if (drop_q || bus.ibus_flush) begin
            state_nxt = IDLE;
          end else begin
            rddata_nxt = bus.mem_rdata;
            state_nxt  = DONE;
          end
        end
      end
      DONE: begin
        if (accept) state_nxt = ADDR;
        else if (ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      addr_nxt = word_align(bus.ibus_addr);
      drop_nxt = 1'b0;
    end
  end

  assign bus.ibus_ready  = ready;
  assign bus.ibus_valid  = (state_q == DONE) & ~bus.ibus_flush;
  assign bus.ibus_rddata = rddata_q;

  assign bus.mem_arid    = AR_ID;
  assign bus.mem_araddr  = addr_q;
  assign bus.mem_arlen   = AXI_LEN_SINGLE;
  assign bus.mem_arsize  = AXI_SIZE_WORD;
  assign bus.mem_arvalid = (state_q == ADDR);
  assign bus.mem_rready  = (state_q == DATA);

endmodule
